// File: rtl/pe_fp_pkg.sv
// rtl/pe_fp_pkg.sv - shared encodings and FP format constants for the PE output stage
package pe_fp_pkg;

    typedef enum logic [1:0] {
        MODE_BF16 = 2'b00,
        MODE_FP16 = 2'b01,
        MODE_FP64 = 2'b10,
        MODE_IDLE = 2'b11
    } mode_e;

    localparam int RES_W        = 107;
    localparam int EXP_W        = 13;
    localparam int FP32_EXP_W   = 8;
    localparam int FP64_EXP_W   = 11;
    localparam int FP32_BIAS    = 127;
    localparam int FP64_BIAS    = 1023;
    localparam int FP32_EXP_MAX = 255;
    localparam int FP64_EXP_MAX = 2047;
    localparam int FP32_MANT_W  = 24;
    localparam int FP64_MANT_W  = 53;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;

    function automatic logic is_dot_mode(input logic [1:0] mode);
        return (mode == MODE_BF16) || (mode == MODE_FP16);
    endfunction

endpackage

// File: rtl/pip3_normalize_if.sv
// rtl/pip3_normalize_if.sv - input beat and output beat handshake bundle for pip3_normalize
interface pip3_normalize_if;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic         in_sign;
    logic         in_sign_fp64;
    logic [11:0]  in_exp_fp64;
    logic [9:0]   in_exp_max;
    logic [106:0] in_result;
    logic [6:0]   in_lza_cnt;
    logic         in_lza_invalid;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic [1:0]   out_mode;
    logic [2:0]   out_flags;

    modport master (
        output in_valid, in_mode, in_sign, in_sign_fp64, in_exp_fp64, in_exp_max,
               in_result, in_lza_cnt, in_lza_invalid, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_flags
    );

    modport slave (
        input  in_valid, in_mode, in_sign, in_sign_fp64, in_exp_fp64, in_exp_max,
               in_result, in_lza_cnt, in_lza_invalid, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_flags
    );
endinterface

// File: rtl/norm_shift107.sv
// rtl/norm_shift107.sv - 107-bit normalizing left shift using the LZA hint plus one-bit correction
module norm_shift107 (
    input  logic [106:0] mag,
    input  logic [6:0]   hint,
    output logic [106:0] norm,
    output logic [7:0]   lz_true
);
    logic [106:0] coarse;

    // The hint may under-count by one; an unset MSB after the coarse shift exposes that.
    always_comb begin
        coarse = mag << hint;
        if (coarse[106]) begin
            norm    = coarse;
            lz_true = {1'b0, hint};
        end else begin
            norm    = coarse << 1;
            lz_true = {1'b0, hint} + 8'd1;
        end
    end
endmodule

// File: rtl/pip3_normalize.sv
// rtl/pip3_normalize.sv - normalize/round/pack pipeline (N, R); optional PIP3_STICKY_FLAGS_EN adds sticky flags
module pip3_normalize
    import pe_fp_pkg::*;
#(
    parameter int EXP_OFS_DP = 1,
    parameter int EXP_OFS_64 = 2
) (
    input  logic              clk,
    input  logic              rst,
    pip3_normalize_if.slave   bus
`ifdef PIP3_STICKY_FLAGS_EN
    ,
    input  logic              flag_clr,
    output logic [2:0]        sticky_flags
`endif
);
    logic         en;
    logic         accept;
    logic         fp64_in;
    logic [106:0] mag;
    logic [106:0] norm;
    logic [7:0]   lz_true;
    logic [12:0]  base;
    logic [12:0]  ofs;
    logic signed [12:0] exp_n;

    logic         n_valid;
    logic [1:0]   n_mode;
    logic         n_sign;
    logic         n_zero;
    logic [106:0] n_norm;
    logic signed [12:0] n_exp;

    // Only the output register can refuse data, so the whole pipe advances as one unit.
    assign en           = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = en;
    assign accept       = bus.in_valid && en && (bus.in_mode != MODE_IDLE);
    assign fp64_in      = (bus.in_mode == MODE_FP64);

    always_comb begin
        if (is_dot_mode(bus.in_mode) && bus.in_sign) begin
            mag = ~bus.in_result + 107'd1;
        end else if (fp64_in) begin
            mag = {1'b0, bus.in_result[105:0]};
        end else begin
            mag = bus.in_result;
        end
        base  = fp64_in ? {1'b0, bus.in_exp_fp64} : {3'b0, bus.in_exp_max};
        ofs   = fp64_in ? 13'(EXP_OFS_64) : 13'(EXP_OFS_DP);
        exp_n = $signed(base + ofs - {5'b0, lz_true});
    end

    norm_shift107 u_shift (
        .mag     (mag),
        .hint    (bus.in_lza_cnt),
        .norm    (norm),
        .lz_true (lz_true)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            n_valid <= 1'b0;
            n_mode  <= MODE_IDLE;
            n_sign  <= 1'b0;
            n_zero  <= 1'b0;
            n_norm  <= '0;
            n_exp   <= '0;
        end else if (en) begin
            n_valid <= accept;
            if (accept) begin
                n_mode <= bus.in_mode;
                n_sign <= bus.in_lza_invalid ? 1'b0 : (fp64_in ? bus.in_sign_fp64 : bus.in_sign);
                n_zero <= bus.in_lza_invalid;
                n_norm <= norm;
                n_exp  <= exp_n;
            end
        end
    end

    logic         fp64_r;
    logic [52:0]  mant;
    logic [53:0]  mant_r;
    logic         guard;
    logic         sticky;
    logic         round_up;
    logic         carry;
    logic         inexact;
    logic signed [12:0] exp_r;
    logic signed [12:0] exp_lim;
    logic [51:0]  frac64;
    logic [22:0]  frac32;
    logic [63:0]  data_r;
    logic [2:0]   flags_r;
    logic         unused_hidden;

    assign unused_hidden = mant_r[52];

    always_comb begin
        fp64_r = (n_mode == MODE_FP64);
        if (fp64_r) begin
            mant   = n_norm[RES_W-1 -: FP64_MANT_W];
            guard  = n_norm[RES_W-1-FP64_MANT_W];
            sticky = |n_norm[RES_W-2-FP64_MANT_W:0];
        end else begin
            mant   = {29'b0, n_norm[RES_W-1 -: FP32_MANT_W]};
            guard  = n_norm[RES_W-1-FP32_MANT_W];
            sticky = |n_norm[RES_W-2-FP32_MANT_W:0];
        end
        round_up = guard && (sticky || mant[0]);
        mant_r   = {1'b0, mant} + {53'b0, round_up};
        // A mantissa carry-out leaves exactly 1.0, so the fraction field is all zeros.
        carry    = fp64_r ? mant_r[FP64_MANT_W] : mant_r[FP32_MANT_W];
        exp_r    = n_exp + (carry ? 13'sd1 : 13'sd0);
        exp_lim  = fp64_r ? 13'(FP64_EXP_MAX) : 13'(FP32_EXP_MAX);
        frac64   = carry ? 52'b0 : mant_r[51:0];
        frac32   = carry ? 23'b0 : mant_r[22:0];
        inexact  = guard || sticky;

        data_r  = '0;
        flags_r = '0;
        if (!n_zero) begin
            if (exp_r >= exp_lim) begin
                data_r = fp64_r ? {n_sign, 11'h7FF, 52'b0} : {32'b0, n_sign, 8'hFF, 23'b0};
                flags_r[FLAG_OF] = 1'b1;
                flags_r[FLAG_NX] = 1'b1;
            end else if (exp_r <= 13'sd0) begin
                data_r = fp64_r ? {n_sign, 63'b0} : {32'b0, n_sign, 31'b0};
                flags_r[FLAG_UF] = 1'b1;
                flags_r[FLAG_NX] = inexact;
            end else begin
                data_r = fp64_r ? {n_sign, exp_r[FP64_EXP_W-1:0], frac64}
                                : {32'b0, n_sign, exp_r[FP32_EXP_W-1:0], frac32};
                flags_r[FLAG_NX] = inexact;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_mode  <= MODE_IDLE;
            bus.out_flags <= '0;
        end else if (en) begin
            bus.out_valid <= n_valid;
            if (n_valid) begin
                bus.out_data  <= data_r;
                bus.out_mode  <= n_mode;
                bus.out_flags <= flags_r;
            end
        end
    end

`ifdef PIP3_STICKY_FLAGS_EN
    // A flag arriving in the same cycle as a clear is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_flags <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            sticky_flags <= (flag_clr ? 3'b000 : sticky_flags) | bus.out_flags;
        end else if (flag_clr) begin
            sticky_flags <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_pip3_normalize.sv
// tb/tb_pip3_normalize.sv - directed self-checking bench for pip3_normalize
module tb_pip3_normalize;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pip3_normalize_if bus ();

`ifdef PIP3_STICKY_FLAGS_EN
    logic       flag_clr;
    logic [2:0] sticky_flags;
`endif

    pip3_normalize dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus)
`ifdef PIP3_STICKY_FLAGS_EN
        ,
        .flag_clr     (flag_clr),
        .sticky_flags (sticky_flags)
`endif
    );

    function automatic logic [69:0] obs();
        return {bus.out_valid, bus.out_mode, bus.out_flags, bus.out_data};
    endfunction

    task automatic idle_inputs();
        bus.in_valid       = 1'b0;
        bus.in_mode        = 2'b00;
        bus.in_sign        = 1'b0;
        bus.in_sign_fp64   = 1'b0;
        bus.in_exp_fp64    = '0;
        bus.in_exp_max     = '0;
        bus.in_result      = '0;
        bus.in_lza_cnt     = '0;
        bus.in_lza_invalid = 1'b0;
        bus.out_ready      = 1'b1;
    endtask

    task automatic drive(input logic [1:0] mode, input logic sgn, input logic sgn64,
                         input logic [11:0] e64, input logic [9:0] emax,
                         input logic [106:0] res, input logic [6:0] lza, input logic inv);
        bus.in_valid       = 1'b1;
        bus.in_mode        = mode;
        bus.in_sign        = sgn;
        bus.in_sign_fp64   = sgn64;
        bus.in_exp_fp64    = e64;
        bus.in_exp_max     = emax;
        bus.in_result      = res;
        bus.in_lza_cnt     = lza;
        bus.in_lza_invalid = inv;
    endtask

    // Present one beat, then stop at the cycle where its result must be visible.
    task automatic one_beat(input logic [1:0] mode, input logic sgn, input logic sgn64,
                            input logic [11:0] e64, input logic [9:0] emax,
                            input logic [106:0] res, input logic [6:0] lza, input logic inv,
                            output logic early);
        @(negedge clk);
        drive(mode, sgn, sgn64, e64, emax, res, lza, inv);
        @(negedge clk);
        bus.in_valid = 1'b0;
        early = bus.out_valid;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [70:0] expv;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        expv = {1'b1, 1'b0, 2'b11, 3'b000, 64'h0};
        checks++;
        if ({bus.in_ready, obs()} !== expv) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", {bus.in_ready, obs()}, expv);
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_fp64();
        logic e;
        logic [69:0] expv;
        one_beat(2'b10, 1'b0, 1'b0, 12'd1023, 10'd0, 107'd1 << 104, 7'd2, 1'b0, e);
        checks++;
        if (e !== 1'b0) begin
            failures++;
            $display("FAIL fp64_latency early_valid got=%b exp=0", e);
        end
        expv = {1'b1, 2'b10, 3'b000, 64'h3FF0000000000000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp64_one got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b10, 1'b0, 1'b0, 12'd2046, 10'd0, 107'd1 << 104, 7'd2, 1'b0, e);
        expv = {1'b1, 2'b10, 3'b000, 64'h7FE0000000000000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp64_max_finite got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b10, 1'b0, 1'b0, 12'd2047, 10'd0, 107'd1 << 104, 7'd2, 1'b0, e);
        expv = {1'b1, 2'b10, 3'b101, 64'h7FF0000000000000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp64_overflow got=%h exp=%h", obs(), expv);
        end
    endtask

    task automatic test_dot_basic();
        logic e;
        logic [106:0] r;
        logic [69:0] expv;
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd127, 107'd1 << 105, 7'd0, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b000, 64'h3F800000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL lza_correction got=%h exp=%h", obs(), expv);
        end
        r = 107'd1 << 105;
        r = ~r + 107'd1;
        one_beat(2'b00, 1'b1, 1'b0, 12'd0, 10'd127, r, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b000, 64'hBF800000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL negative_one got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b01, 1'b0, 1'b1, 12'd0, 10'd130, 107'd3 << 104, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b01, 3'b000, 64'h41400000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp16_mode got=%h exp=%h", obs(), expv);
        end
    endtask

    task automatic test_rounding();
        logic e;
        logic [69:0] expv;
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd127, {1'b0, 24'h800001, 1'b1, 81'b0}, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b001, 64'h3F800002};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL rne_tie_odd got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd127, {1'b0, 24'h800000, 1'b1, 81'b0}, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b001, 64'h3F800000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL rne_tie_even got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd127, {1'b0, 24'hFFFFFF, 1'b1, 81'b0}, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b001, 64'h40000000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL round_carry got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd300, {1'b0, 24'hFFFFFF, 1'b1, 81'b0}, 7'd1, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b101, 64'h7F800000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL round_carry_overflow got=%h exp=%h", obs(), expv);
        end
    endtask

    task automatic test_underflow_zero();
        logic e;
        logic [69:0] expv;
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd0, 107'd1 << 105, 7'd0, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b010, 64'h0};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp32_underflow got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd1, 107'd1 << 105, 7'd0, 1'b0, e);
        expv = {1'b1, 2'b00, 3'b000, 64'h00800000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp32_min_normal got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b10, 1'b0, 1'b1, 12'd100, 10'd0, 107'd1, 7'd105, 1'b0, e);
        expv = {1'b1, 2'b10, 3'b010, 64'h8000000000000000};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL fp64_large_lz got=%h exp=%h", obs(), expv);
        end
        one_beat(2'b00, 1'b1, 1'b0, 12'd0, 10'd200, 107'd12345, 7'd3, 1'b1, e);
        expv = {1'b1, 2'b00, 3'b000, 64'h0};
        checks++;
        if (obs() !== expv) begin
            failures++;
            $display("FAIL lza_invalid_zero got=%h exp=%h", obs(), expv);
        end
    endtask

    task automatic test_idle_drop();
        int seen = 0;
        @(negedge clk);
        drive(2'b11, 1'b0, 1'b0, 12'd1023, 10'd127, 107'd1 << 105, 7'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid) seen++;
            @(negedge clk);
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL idle_mode_dropped out_valid_cycles got=%0d exp=0", seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] expq [4];
        logic [63:0] held = '0;
        logic        held_v = 1'b0;
        logic        stall;
        int sent = 0;
        int rcv  = 0;
        for (int i = 0; i < 4; i++) expq[i] = 64'(120 + i) << 23;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            stall = (cyc >= 3) && (cyc <= 5);
            bus.out_ready = !stall;
            if (sent < 4) drive(2'b00, 1'b0, 1'b0, 12'd0, 10'(120 + sent), 107'd1 << 105, 7'd0, 1'b0);
            else bus.in_valid = 1'b0;
            #1;
            checks++;
            if (bus.in_ready !== !stall) begin
                failures++;
                $display("FAIL b2b_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, !stall);
            end
            if (held_v) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    failures++;
                    $display("FAIL b2b_hold cyc=%0d got=%b/%h exp=1/%h", cyc, bus.out_valid, bus.out_data, held);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (rcv >= 4) begin
                    failures++;
                    $display("FAIL b2b_extra_beat got=%h exp=none", bus.out_data);
                end else if (bus.out_data !== expq[rcv] || bus.out_flags !== 3'b000) begin
                    failures++;
                    $display("FAIL b2b_order beat=%0d got=%h/%b exp=%h/000", rcv, bus.out_data, bus.out_flags, expq[rcv]);
                end
                rcv++;
            end
            held_v = bus.out_valid && !bus.out_ready;
            held   = bus.out_data;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (rcv != 4) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=4", rcv);
        end
    endtask

    task automatic test_reset_during_stall();
        logic [70:0] expv;
        int seen = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 12'd0, 10'd127, 107'd1 << 105, 7'd0, 1'b0);
        @(negedge clk);
        drive(2'b00, 1'b0, 1'b0, 12'd0, 10'd128, 107'd1 << 105, 7'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_setup got=%b/%b exp=1/0", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        expv = {1'b1, 1'b0, 2'b11, 3'b000, 64'h0};
        checks++;
        if ({bus.in_ready, obs()} !== expv) begin
            failures++;
            $display("FAIL reset_in_stall got=%h exp=%h", {bus.in_ready, obs()}, expv);
        end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL reset_discards_inflight got=%0d exp=0", seen);
        end
    endtask

`ifdef PIP3_STICKY_FLAGS_EN
    task automatic test_sticky();
        logic e;
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd300, {1'b0, 24'hFFFFFF, 1'b1, 81'b0}, 7'd1, 1'b0, e);
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b101) begin
            failures++;
            $display("FAIL sticky_of got=%b exp=101", sticky_flags);
        end
        one_beat(2'b00, 1'b0, 1'b0, 12'd0, 10'd0, 107'd1 << 105, 7'd0, 1'b0, e);
        @(negedge clk);
        checks++;
        if (sticky_flags !== 3'b111) begin
            failures++;
            $display("FAIL sticky_accum got=%b exp=111", sticky_flags);
        end
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        checks++;
        if (sticky_flags !== 3'b000) begin
            failures++;
            $display("FAIL sticky_clear got=%b exp=000", sticky_flags);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef PIP3_STICKY_FLAGS_EN
        flag_clr = 1'b0;
`endif
        test_reset();
        test_fp64();
        test_dot_basic();
        test_rounding();
        test_underflow_zero();
        test_idle_drop();
        test_back_to_back();
        test_reset_during_stall();
`ifdef PIP3_STICKY_FLAGS_EN
        test_sticky();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
